// File: rtl/hal_op_sequencer.sv
// Key-driven operation sequencer: turns debounced key levels into single-cycle
// register-bank/ALU strobes in the clk domain and latches the switch operands.
module hal_op_sequencer #(
   parameter int OP_W   = 4,
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key0_db,
   input  logic              key3_db,
   input  logic [OP_W-1:0]   codop,
   input  logic [ADDR_W-1:0] sw_s2,
   input  logic [ADDR_W-1:0] sw_s3,
   input  logic [ADDR_W-1:0] sw_s4,
   output logic [ADDR_W-1:0] rf_addr_a,
   output logic [ADDR_W-1:0] rf_addr_b,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic              rf_we,
   output logic [OP_W-1:0]   alu_codop,
   output logic              alu_en,
   output logic              sel_imm,
   output logic [ADDR_W-1:0] imm,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  op_count
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SHOW = 3'd1,
      READ = 3'd2,
      EXEC = 3'd3,
      WB   = 3'd4
   } state_t;

   state_t            state_r;
   logic              k0_r;
   logic              k3_r;
   logic [ADDR_W-1:0] op_s4_r;
   logic              rise0_s;
   logic              rise3_s;

   // Opcodes whose second ALU operand is the immediate field rather than register B.
   function automatic logic imm_select(input logic [OP_W-1:0] op);
      return op[3] | (op[1] & (~op[0] | op[2]));
   endfunction

   assign rise0_s = key0_db & ~k0_r;
   assign rise3_s = key3_db & ~k3_r;

   // Sequencer FSM; every output is a register set on the edge entering its state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         k0_r      <= 1'b0;
         k3_r      <= 1'b0;
         op_s4_r   <= {ADDR_W{1'b0}};
         rf_addr_a <= {ADDR_W{1'b0}};
         rf_addr_b <= {ADDR_W{1'b0}};
         rf_waddr  <= {ADDR_W{1'b0}};
         rf_we     <= 1'b0;
         alu_codop <= {OP_W{1'b0}};
         alu_en    <= 1'b0;
         sel_imm   <= 1'b0;
         imm       <= {ADDR_W{1'b0}};
         busy      <= 1'b0;
         done      <= 1'b0;
         op_count  <= {CNT_W{1'b0}};
      end else begin
         // Edge detectors keep tracking while busy, so a held key never retriggers.
         k0_r   <= key0_db;
         k3_r   <= key3_db;
         rf_we  <= 1'b0;
         alu_en <= 1'b0;
         done   <= 1'b0;
         case (state_r)
            IDLE, SHOW: begin
               if (rise3_s) begin
                  state_r   <= READ;
                  alu_codop <= codop;
                  imm       <= sw_s3;
                  sel_imm   <= imm_select(codop);
                  op_s4_r   <= sw_s4;
                  rf_addr_a <= sw_s2;
                  rf_addr_b <= sw_s3;
                  busy      <= 1'b1;
               end else if (rise0_s) begin
                  state_r   <= SHOW;
                  rf_addr_a <= sw_s4;
                  rf_addr_b <= sw_s3;
               end else begin
                  state_r <= state_r;
               end
            end
            READ: begin
               state_r <= EXEC;
               alu_en  <= 1'b1;
            end
            EXEC: begin
               state_r  <= WB;
               rf_we    <= 1'b1;
               rf_waddr <= op_s4_r;
            end
            WB: begin
               state_r  <= IDLE;
               busy     <= 1'b0;
               done     <= 1'b1;
               op_count <= op_count + CNT_W'(1);
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
